// File: rtl/block_state_manager.sv
// Brick-field state register: level load, hit serialisation, clear detect.
// Optional hard bricks are built in when HARD_BLOCKS_EN is defined.
module block_state_manager #(
    parameter int BLOCKS_PER_ROW = 13,
    parameter int NUM_ROWS       = 16,
    parameter int NUM_BLOCKS     = 208,
    parameter int IDX_W          = 8
) (
    input  logic                        clk,
    input  logic                        nRst,
    input  logic                        level_start,
    output logic [$clog2(NUM_ROWS)-1:0] pattern_row,
    input  logic [BLOCKS_PER_ROW-1:0]   pattern_bits,
`ifdef HARD_BLOCKS_EN
    input  logic [BLOCKS_PER_ROW-1:0]   pattern_hard,
    output logic                        hit_destroyed,
`endif
    input  logic                        hit_req,
    input  logic [IDX_W-1:0]            hit_idx,
    output logic                        hit_ack,
    output logic                        hit_was_present,
    output logic [NUM_BLOCKS-1:0]       block_state,
    output logic [IDX_W-1:0]            blocks_left,
    output logic                        level_clear,
    output logic                        busy
);

    localparam int ROW_W = $clog2(NUM_ROWS);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);
    localparam logic [IDX_W-1:0] NB = IDX_W'(NUM_BLOCKS);
    localparam logic [IDX_W-1:0] BPR = IDX_W'(BLOCKS_PER_ROW);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PLAY = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [NUM_BLOCKS-1:0]   r_block_state;
    logic [IDX_W-1:0]        r_blocks_left;
    logic [ROW_W-1:0]        r_row;
    logic                    r_ack;
    logic                    r_present;
    logic                    r_clear;

    logic                    w_accept;
    logic                    w_in_range;
    logic                    w_present;
    logic                    w_kill;
    logic                    w_hard_bit;
    logic [IDX_W-1:0]        w_pop;
    logic [IDX_W-1:0]        w_load_sum;
    logic [IDX_W-1:0]        w_row_base;

`ifdef HARD_BLOCKS_EN
    logic [NUM_BLOCKS-1:0]   r_hard;
    logic                    r_destroyed;
`endif

    assign w_in_range = (hit_idx < NB);
    assign w_row_base = IDX_W'(r_row) * BPR;
    assign w_load_sum = r_blocks_left + w_pop;

`ifdef HARD_BLOCKS_EN
    assign w_hard_bit = w_in_range ? r_hard[hit_idx] : 1'b0;
`else
    assign w_hard_bit = 1'b0;
`endif

    // Hit lookup: only a PLAY-state hit can find a brick
    always_comb begin
        w_present = 1'b0;
        if (r_state == ST_PLAY && w_in_range) begin
            w_present = r_block_state[hit_idx];
        end
        w_kill = w_present & ~w_hard_bit;
    end

    // Population count of the row being loaded
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < BLOCKS_PER_ROW; i++) begin
            w_pop = w_pop + IDX_W'(pattern_bits[i]);
        end
    end

    // Next state and request acceptance; level_start beats a hit
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (level_start) begin
                    w_state_next = ST_LOAD;
                end else begin
                    w_accept = hit_req & ~r_ack;
                end
            end
            ST_LOAD: begin
                if (r_row == LAST_ROW) begin
                    w_state_next = (w_load_sum == '0) ? ST_IDLE : ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (level_start) begin
                    w_state_next = ST_LOAD;
                end else begin
                    w_accept = hit_req & ~r_ack;
                    if (w_accept && w_kill && r_blocks_left == IDX_W'(1)) begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State, brick map, counters and response pulses
    always_ff @(posedge clk) begin
        if (!nRst) begin
            r_state       <= ST_IDLE;
            r_block_state <= '0;
            r_blocks_left <= '0;
            r_row         <= '0;
            r_ack         <= 1'b0;
            r_present     <= 1'b0;
            r_clear       <= 1'b0;
`ifdef HARD_BLOCKS_EN
            r_hard        <= '0;
            r_destroyed   <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_next;
            r_ack     <= w_accept;
            r_present <= w_accept & w_present;
            r_clear   <= 1'b0;
`ifdef HARD_BLOCKS_EN
            r_destroyed <= w_accept & w_kill;
`endif
            unique case (r_state)
                ST_IDLE, ST_PLAY: begin
                    if (level_start) begin
                        r_row         <= '0;
                        r_blocks_left <= '0;
                    end else if (w_accept && w_present) begin
                        if (w_kill && r_blocks_left != '0) begin
                            r_block_state[hit_idx] <= 1'b0;
                            r_blocks_left <= r_blocks_left - IDX_W'(1);
                            if (r_blocks_left == IDX_W'(1)) begin
                                r_clear <= 1'b1;
                            end
                        end
`ifdef HARD_BLOCKS_EN
                        if (w_hard_bit) begin
                            r_hard[hit_idx] <= 1'b0;
                        end
`endif
                    end
                end
                ST_LOAD: begin
                    r_block_state[w_row_base +: BLOCKS_PER_ROW] <= pattern_bits;
`ifdef HARD_BLOCKS_EN
                    r_hard[w_row_base +: BLOCKS_PER_ROW] <=
                        pattern_hard & pattern_bits;
`endif
                    r_blocks_left <= w_load_sum;
                    r_row         <= r_row + ROW_W'(1);
                    if (r_row == LAST_ROW && w_load_sum == '0) begin
                        r_clear <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign pattern_row     = r_row;
    assign hit_ack         = r_ack;
    assign hit_was_present = r_present;
    assign block_state     = r_block_state;
    assign blocks_left     = r_blocks_left;
    assign level_clear     = r_clear;
    assign busy            = (r_state == ST_LOAD);
`ifdef HARD_BLOCKS_EN
    assign hit_destroyed   = r_destroyed;
`endif

endmodule

// File: tb/tb_block_state_manager.sv
// Directed bench for block_state_manager with a hit-response scoreboard.
// Define HARD_BLOCKS_EN to also exercise hard bricks.
module tb_block_state_manager;

    logic         clk;
    logic         nRst;
    logic         level_start;
    logic [3:0]   pattern_row;
    logic [12:0]  pattern_bits;
    logic [12:0]  pattern_hard;
    logic         hit_destroyed;
    logic         hit_req;
    logic [7:0]   hit_idx;
    logic         hit_ack;
    logic         hit_was_present;
    logic [207:0] block_state;
    logic [7:0]   blocks_left;
    logic         level_clear;
    logic         busy;

    logic [12:0]  pat  [16];
    logic [12:0]  hard [16];

    typedef struct packed {
        logic p;
        logic d;
        logic c;
    } exp_t;
    exp_t sb[$];

    logic [207:0] m_map;
    logic [207:0] m_hard;
    int           m_left;
    int           n_cmp;
    int           n_err;

    assign pattern_bits = pat[pattern_row];
    assign pattern_hard = hard[pattern_row];

    block_state_manager dut (
        .clk            (clk),
        .nRst           (nRst),
        .level_start    (level_start),
        .pattern_row    (pattern_row),
        .pattern_bits   (pattern_bits),
`ifdef HARD_BLOCKS_EN
        .pattern_hard   (pattern_hard),
        .hit_destroyed  (hit_destroyed),
`endif
        .hit_req        (hit_req),
        .hit_idx        (hit_idx),
        .hit_ack        (hit_ack),
        .hit_was_present(hit_was_present),
        .block_state    (block_state),
        .blocks_left    (blocks_left),
        .level_clear    (level_clear),
        .busy           (busy)
    );

`ifndef HARD_BLOCKS_EN
    assign hit_destroyed = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [207:0] obs,
                       input logic [207:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_pat(input logic [12:0] r0, input logic [12:0] rest,
                           input logic [12:0] h0);
        for (int r = 0; r < 16; r++) begin
            pat[r]  = (r == 0) ? r0 : rest;
            hard[r] = (r == 0) ? h0 : 13'h0;
        end
    endtask

    task automatic model_load();
        m_left = 0;
        for (int r = 0; r < 16; r++) begin
            for (int b = 0; b < 13; b++) begin
                m_map[r*13+b] = pat[r][b];
`ifdef HARD_BLOCKS_EN
                m_hard[r*13+b] = pat[r][b] & hard[r][b];
`endif
                m_left += int'(pat[r][b]);
            end
        end
    endtask

    task automatic do_load();
        int cyc;
        level_start = 1'b1;
        tick();
        level_start = 1'b0;
        cyc = 0;
        for (int r = 0; r < 16; r++) begin
            chk("load_busy", 208'(busy), 208'(1));
            chk("load_row", 208'(pattern_row), 208'(r));
            tick();
            cyc++;
        end
        model_load();
        chk("load_busy_end", 208'(busy), 208'(0));
        chk("load_left", 208'(blocks_left), 208'(m_left));
        chk("load_map", block_state, m_map);
        chk("load_clear", 208'(level_clear), 208'(m_left == 0));
        if (m_left == 0) begin
            tick();
            chk("load_clear_pulse", 208'(level_clear), 208'(0));
        end
    endtask

    task automatic do_hit(input int idx, input bit with_load,
                          input int exp_lat);
        exp_t e;
        bit   p;
        bit   k;
        int   lat;
        if (with_load) model_load();
        p = (idx < 208) ? m_map[idx] : 1'b0;
        k = p && ((idx < 208) ? !m_hard[idx] : 1'b1);
        if (p && !k) m_hard[idx] = 1'b0;
        e.c = 1'b0;
        if (k) begin
            m_map[idx] = 1'b0;
            m_left--;
            e.c = (m_left == 0);
        end
        e.p = p;
        e.d = k;
        sb.push_back(e);
        hit_req = 1'b1;
        hit_idx = 8'(idx);
        if (with_load) level_start = 1'b1;
        lat = 0;
        do begin
            tick();
            level_start = 1'b0;
            lat++;
        end while (!hit_ack && lat < 40);
        chk("hit_ack", 208'(hit_ack), 208'(1));
        chk("hit_latency", 208'(lat), 208'(exp_lat));
        e = sb.pop_front();
        chk("hit_present", 208'(hit_was_present), 208'(e.p));
`ifdef HARD_BLOCKS_EN
        chk("hit_destroyed", 208'(hit_destroyed), 208'(e.d));
`endif
        chk("hit_clear", 208'(level_clear), 208'(e.c));
        chk("hit_left", 208'(blocks_left), 208'(m_left));
        chk("hit_map", block_state, m_map);
        hit_req = 1'b0;
        tick();
        chk("hit_ack_pulse", 208'(hit_ack), 208'(0));
        chk("hit_clear_pulse", 208'(level_clear), 208'(0));
    endtask

    task automatic chk_reset_vals();
        chk("rst_map", block_state, 208'(0));
        chk("rst_left", 208'(blocks_left), 208'(0));
        chk("rst_row", 208'(pattern_row), 208'(0));
        chk("rst_ack", 208'(hit_ack), 208'(0));
        chk("rst_present", 208'(hit_was_present), 208'(0));
        chk("rst_clear", 208'(level_clear), 208'(0));
        chk("rst_busy", 208'(busy), 208'(0));
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        nRst = 1'b0;
        level_start = 1'b0;
        hit_req = 1'b0;
        hit_idx = 8'd0;
        m_map = '0;
        m_hard = '0;
        m_left = 0;
        set_pat(13'h0, 13'h0, 13'h0);

        tick();
        tick();
        chk_reset_vals();
        nRst = 1'b1;
        tick();

        do_hit(5, 1'b0, 1);

        set_pat(13'h1FFF, 13'h1FFF, 13'h0);
        do_load();
        do_hit(14, 1'b0, 1);
        do_hit(14, 1'b0, 1);
        do_hit(250, 1'b0, 1);
        do_hit(207, 1'b0, 1);

        set_pat(13'h0001, 13'h0, 13'h0);
        do_load();
        do_hit(0, 1'b0, 1);
        do_hit(0, 1'b0, 1);

        set_pat(13'h0, 13'h0, 13'h0);
        do_load();

        for (int r = 0; r < 16; r++) begin
            pat[r]  = 13'((r * 13'h0A53) ^ (r << 3));
            hard[r] = 13'h0;
        end
        do_load();

        set_pat(13'h1FFF, 13'h1FFF, 13'h0);
        do_load();
        do_hit(20, 1'b1, 18);

        level_start = 1'b1;
        tick();
        level_start = 1'b0;
        for (int r = 0; r < 7; r++) tick();
        chk("mid_load_row", 208'(pattern_row), 208'(7));
        chk("mid_load_busy", 208'(busy), 208'(1));
        nRst = 1'b0;
        tick();
        chk_reset_vals();
        m_map = '0;
        m_hard = '0;
        m_left = 0;
        nRst = 1'b1;
        tick();
        chk_reset_vals();

`ifdef HARD_BLOCKS_EN
        set_pat(13'h0003, 13'h0, 13'h0003);
        do_load();
        do_hit(0, 1'b0, 1);
        do_hit(0, 1'b0, 1);
        do_hit(1, 1'b0, 1);
        do_hit(1, 1'b0, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/block_state_manager.md
Name: block_state_manager

Overview:
Owns the 208-bit brick-field state register that the block renderer reads every pixel. It loads a level pattern row by row and serialises hit requests from the ball/collision logic into clear operations. It tracks the number of remaining bricks and pulses when the field is cleared. It sits between the game controller (level start), the collision unit (hit requests) and the block renderer (block_state).

Parameters:
BLOCKS_PER_ROW, 13, bricks per row; also the width of pattern_bits.
NUM_ROWS, 16, brick rows.
NUM_BLOCKS, 208, equals BLOCKS_PER_ROW*NUM_ROWS; the width of block_state.
IDX_W, 8, brick index width.

Ports:
clk  in  1  system clock
nRst  in  1  reset; synchronous, active-low; sampled on the rising edge of clk
level_start  in  1  one-cycle pulse: load a new level
pattern_row  out  4  row currently being loaded
pattern_bits  in  13  pattern for pattern_row; bit i is brick (row*13+i); combinational source, valid in the same cycle
hit_req  in  1  hit request; held until hit_ack
hit_idx  in  8  brick index to hit; stable while hit_req=1
hit_ack  out  1  one-cycle pulse: request completed
hit_was_present  out  1  valid with hit_ack; 1 = brick existed and was hit
block_state  out  208  registered brick map, 1 = brick present
blocks_left  out  8  registered count of present bricks
level_clear  out  1  one-cycle pulse when blocks_left reaches 0
busy  out  1  high in LOAD

Behaviour:
- Reset (nRst=0 at a clk edge) sets:
  - state=IDLE
  - block_state=0, blocks_left=0, pattern_row=0
  - hit_ack=0, hit_was_present=0, level_clear=0, busy=0
- Reset mid-LOAD or mid-hit aborts the operation with no partial side effects after the reset edge.
- FSM states: IDLE, LOAD, PLAY.
- IDLE:
  - level_start → LOAD, with pattern_row=0 and blocks_left=0.
  - A request is accepted when hit_req=1 and hit_ack=0 at a clk edge.
  - Accepted requests are acked next cycle with hit_was_present=0.
- LOAD (16 cycles):
  - Each cycle, row pattern_row of block_state ← pattern_bits.
  - blocks_left += popcount(pattern_bits).
  - pattern_row increments each cycle.
  - After row 15:
    - blocks_left≠0 → PLAY.
    - blocks_left=0 → IDLE with a level_clear pulse.
  - level_start is ignored in LOAD.
  - hit_req is not accepted in LOAD (stalled, no ack).
- PLAY:
  - An accepted request completes with one-cycle latency.
  - On the accept edge the brick bit is cleared and blocks_left decrements if the bit was 1.
  - The next cycle has hit_ack=1, with hit_was_present = prior bit value.
  - Maximum rate is one request per 2 cycles.
  - hit_idx ≥ 208 → ack with present=0 and no state change.
  - A hit on an absent brick → ack with present=0.
- Level clear:
  - When a hit decrements blocks_left from 1 to 0, level_clear pulses in the same cycle as hit_ack.
  - The FSM goes to IDLE.
- level_start in PLAY:
  - Has priority over a same-cycle hit_req; the hit is not accepted.
  - Enters LOAD; the pending hit is served after LOAD.
- blocks_left never underflows or exceeds 208.
- block_state changes only on clk edges; the renderer sees a stable map within a cycle.

Optional Feature:
HARD_BLOCKS_EN.
- When defined:
  - Adds input pattern_hard[13], sampled alongside pattern_bits in LOAD; a hard bit is stored only where pattern_bits is 1.
  - Adds a 208-bit hard register (reset 0).
  - Adds output hit_destroyed[1], valid with hit_ack.
  - A hit on a present hard brick clears only the hard bit: hit_was_present=1, hit_destroyed=0, blocks_left unchanged.
  - A hit on a present normal brick behaves as the base design, with hit_destroyed=1.
- When undefined: no hard register or ports; every brick is destroyed on its first hit.

Test Plan:
- Reset then idle: nRst low 2 cycles → block_state=0, blocks_left=0, all pulses 0; hit_req idx 5 → ack 1 cycle after accept, present=0.
- Load all-ones pattern: level_start → busy high exactly 16 cycles, pattern_row 0..15, then block_state all ones, blocks_left=208, state PLAY.
- Hit sequence: idx 14 → ack next cycle, present=1, bit 14=0, blocks_left=207; repeat idx 14 → present=0, blocks_left=207; idx 250 → present=0, no change.
- Clear level: pattern row 0=0x0001, others 0 → blocks_left=1; hit idx 0 → hit_ack, level_clear same cycle, blocks_left=0, IDLE; an all-zero pattern gives level_clear at end of LOAD.
- Priority and reset: hit_req concurrent with level_start in PLAY → LOAD runs, hit acked after LOAD; nRst low in LOAD row 7 → all outputs at reset values next cycle.
- HARD_BLOCKS_EN: row 0 hard=0x0003 → hit idx 0 twice: first present=1/destroyed=0/blocks_left unchanged, second destroyed=1/decrement.
